// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Stall/flush sequencer for the 5-stage 16-bit RISC pipeline. Resolves
//   data-cache misses (RUN -> MISS -> RESUME with a refill latency counter),
//   load-use hazards (one ID/EX bubble) and taken branches (IF/ID flush).
//   Priority: miss/MISS/RESUME > branch_taken > load-use > normal.
//
// Parameters
//   MISS_LATENCY  refill cycles spent in MISS (1..15)
//   REG_AW        register-address width
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   mem_access, hit     MEM-stage load/store valid, data-cache hit
//   ex_mem_read, ex_rt  EX-stage load and its destination register
//   id_rs, id_rt        ID-stage source registers
//   id_uses_rt          ID instruction reads id_rt
//   branch_taken        EX-stage branch resolved taken
//   pc_write            PC update enable
//   if_id_write         IF/ID load enable
//   if_id_flush         IF/ID clear to NOP
//   id_ex_bubble        ID/EX loads NOP
//   pipe_hold           EX/MEM and MEM/WB hold
//   refill_req          one-cycle pulse starting a cache refill
//   miss_busy           sequencer is in MISS or RESUME
//
// Optional feature (macro HAZARD_PERF_CNT_EN)
//   Adds saturating 16-bit counters miss_stall_cycles, lu_stall_cycles and
//   br_flush_count. Without the macro these ports do not exist.

module pipeline_hazard_ctrl #(
  parameter int MISS_LATENCY = 4,
  parameter int REG_AW       = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_access,
  input  logic              hit,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic              branch_taken,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              if_id_flush,
  output logic              id_ex_bubble,
  output logic              pipe_hold,
  output logic              refill_req,
  output logic              miss_busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0]       miss_stall_cycles,
  output logic [15:0]       lu_stall_cycles,
  output logic [15:0]       br_flush_count
`endif
);

  typedef enum logic [1:0] {ST_RUN, ST_MISS, ST_RESUME} state_e;

  localparam logic [3:0] LAT_M1 = 4'(MISS_LATENCY - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic miss_run;
  logic load_use;
  logic br_run;
  logic lu_run;

  // miss only matters in RUN; MISS/RESUME ignore the cache inputs entirely
  assign miss_run = (state_q == ST_RUN) && mem_access && !hit;

  // r0 is hardwired zero, so a load into r0 never creates a dependency
  assign load_use = ex_mem_read && (ex_rt != '0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  assign br_run = (state_q == ST_RUN) && !miss_run && branch_taken;
  assign lu_run = (state_q == ST_RUN) && !miss_run && !branch_taken && load_use;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (miss_run) begin
          state_d = ST_MISS;
          cnt_d   = LAT_M1;
        end
      end
      ST_MISS: begin
        // counter starts at MISS_LATENCY-1, so MISS lasts MISS_LATENCY cycles
        if (cnt_q == 4'd0) state_d = ST_RESUME;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_RESUME: state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_hold    = 1'b0;
    refill_req   = 1'b0;
    miss_busy    = 1'b0;
    if (!rst_n) begin
      // reset forces a safe pipeline: frozen PC, NOPs injected
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (state_q != ST_RUN) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      pipe_hold   = 1'b1;
      miss_busy   = 1'b1;
    end else if (miss_run) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      pipe_hold   = 1'b1;
      refill_req  = 1'b1;
    end else if (branch_taken) begin
      // branch wins over load-use: the dependent ID instruction is squashed
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (load_use) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] miss_cnt_q, lu_cnt_q, br_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_cnt_q <= 16'd0;
      lu_cnt_q   <= 16'd0;
      br_cnt_q   <= 16'd0;
    end else begin
      // detect cycle, every MISS cycle and RESUME all count as stalled
      if (miss_run || (state_q != ST_RUN)) miss_cnt_q <= sat_inc(miss_cnt_q);
      if (lu_run) lu_cnt_q <= sat_inc(lu_cnt_q);
      if (br_run) br_cnt_q <= sat_inc(br_cnt_q);
    end
  end

  assign miss_stall_cycles = miss_cnt_q;
  assign lu_stall_cycles   = lu_cnt_q;
  assign br_flush_count    = br_cnt_q;
`else
  logic unused_run;
  assign unused_run = br_run ^ lu_run;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl (default build, MISS_LATENCY=4).
// Each cycle the expected output vector is pushed when inputs are driven and
// popped/compared at the following negedge.
// Vector order: {pc_write, if_id_write, if_id_flush, id_ex_bubble,
//                pipe_hold, refill_req, miss_busy}

module tb_pipeline_hazard_ctrl;
  localparam int ML = 4;

  logic       clk;
  logic       rst_n;
  logic       mem_access, hit, ex_mem_read, id_uses_rt, branch_taken;
  logic [2:0] ex_rt, id_rs, id_rt;
  logic       pc_write, if_id_write, if_id_flush, id_ex_bubble;
  logic       pipe_hold, refill_req, miss_busy;

  logic [6:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int stall_left = 0;   // remaining cycles of a miss stall after the current one
  int hold_n, refill_n, busy_n, flush_n;

  pipeline_hazard_ctrl #(.MISS_LATENCY(ML), .REG_AW(3)) dut (
    .clk(clk), .rst_n(rst_n), .mem_access(mem_access), .hit(hit),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .branch_taken(branch_taken),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .pipe_hold(pipe_hold),
    .refill_req(refill_req), .miss_busy(miss_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] model();
    logic lu;
    lu = ex_mem_read && (ex_rt != 3'd0) &&
         ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    if (!rst_n)                  return 7'b0011000;
    if (stall_left > 0)          return 7'b0000101;
    if (mem_access && !hit)      return 7'b0000110;
    if (branch_taken)            return 7'b1011000;
    if (lu)                      return 7'b0001000;
    return 7'b1100000;
  endfunction

  task automatic cyc(input string tag, input logic rn, input logic ma, input logic h,
                     input logic emr, input logic [2:0] ert, input logic [2:0] irs,
                     input logic [2:0] irt, input logic iur, input logic bt);
    logic [6:0] got, e;
    rst_n = rn; mem_access = ma; hit = h; ex_mem_read = emr;
    ex_rt = ert; id_rs = irs; id_rt = irt; id_uses_rt = iur; branch_taken = bt;
    exp_q.push_back(model());
    @(negedge clk);
    got = {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold, refill_req, miss_busy};
    hold_n   += int'(pipe_hold);
    refill_n += int'(refill_req);
    busy_n   += int'(miss_busy);
    flush_n  += int'(if_id_flush);
    e = exp_q.pop_front();
    chk(tag, 16'(got), 16'(e));
    @(posedge clk);
    if (!rst_n)                    stall_left = 0;
    else if (stall_left > 0)       stall_left--;
    else if (mem_access && !hit)   stall_left = ML + 1;
    #1;
  endtask

  task automatic clr_cnt();
    hold_n = 0; refill_n = 0; busy_n = 0; flush_n = 0;
  endtask

  initial begin
    rst_n = 1'b0; mem_access = 0; hit = 1; ex_mem_read = 0; id_uses_rt = 0;
    branch_taken = 0; ex_rt = 0; id_rs = 0; id_rt = 0;
    clr_cnt();
    @(posedge clk); #1;

    // reset held while inputs toggle
    for (int i = 0; i < 4; i++)
      cyc("rst_hold", 0, i[0], ~i[0], 1, 3'd3, 3'd3, 3'd3, 1, i[1]);
    cyc("rel_first", 1, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc("idle", 1, 0, 1, 0, 0, 0, 0, 0, 0);

    // single miss then hits
    clr_cnt();
    cyc("miss_det", 1, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) cyc("miss_seq", 1, 1, 1, 0, 0, 0, 0, 0, 0);
    chk("hold_cycles", 16'(hold_n), 16'd6);
    chk("refill_cycles", 16'(refill_n), 16'd1);
    chk("busy_cycles", 16'(busy_n), 16'd5);

    // load-use variants
    cyc("lu_rs", 1, 0, 1, 1, 3'd3, 3'd3, 3'd0, 0, 0);
    cyc("lu_gone", 1, 0, 1, 0, 3'd3, 3'd3, 3'd0, 0, 0);
    cyc("lu_r0", 1, 0, 1, 1, 3'd0, 3'd0, 3'd0, 1, 0);
    cyc("lu_rt_unused", 1, 0, 1, 1, 3'd3, 3'd1, 3'd3, 0, 0);
    cyc("lu_rt_used", 1, 0, 1, 1, 3'd3, 3'd1, 3'd3, 1, 0);

    // branch beats load-use
    cyc("br_lu", 1, 0, 1, 1, 3'd3, 3'd3, 3'd0, 0, 1);
    cyc("br_only", 1, 0, 1, 0, 3'd0, 3'd0, 3'd0, 0, 1);

    // miss while branch taken: 6 stall cycles then flush
    clr_cnt();
    cyc("miss_br_det", 1, 1, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) cyc("miss_br", 1, 1, 1, 0, 0, 0, 0, 0, 1);
    chk("miss_br_hold", 16'(hold_n), 16'd6);
    chk("miss_br_flush", 16'(flush_n), 16'd1);

    // back-to-back misses, no lockout
    clr_cnt();
    for (int i = 0; i < 12; i++) cyc("b2b_miss", 1, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("b2b_refill", 16'(refill_n), 16'd2);
    chk("b2b_hold", 16'(hold_n), 16'd12);
    cyc("b2b_tail", 1, 0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc("b2b_drain", 1, 0, 1, 0, 0, 0, 0, 0, 0);

    // reset in the 2nd MISS cycle aborts the refill
    cyc("abort_det", 1, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc("abort_miss1", 1, 1, 1, 0, 0, 0, 0, 0, 0);
    cyc("abort_rst", 0, 1, 1, 0, 0, 0, 0, 0, 0);
    clr_cnt();
    for (int i = 0; i < 8; i++) cyc("abort_after", 1, 1, 1, 0, 0, 0, 0, 0, 0);
    chk("abort_refill", 16'(refill_n), 16'd0);
    chk("abort_busy", 16'(busy_n), 16'd0);

    // random traffic
    for (int i = 0; i < 300; i++)
      cyc("rand", ($urandom_range(0, 40) != 0), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 2) != 0), $urandom_range(0, 1) == 1,
          3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
          3'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
          ($urandom_range(0, 4) == 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
